tile_pixel_fetch: RTL and testbench
===================================

// Module: tile_pixel_fetch
// PURPOSE
//  Downstream of the background tile-map stage. Takes a tile number and in-tile pixel offsets (0..9, 0..9)
//  and fetches that pixel's 16-bit colour from tile-graphics memory over a req/ack port.
//  Each tile is 10x10 pixels stored row-major, 2 pixels per 32-bit word, 50 words per tile.
//  A one-word reuse buffer skips the memory read when consecutive pixels share a word.
//  Output is one colour per accepted request, under valid/ready flow control.
// PARAMETERS
//  TILE_BASE    30'h0001000  word address of tile 0 in tile-graphics memory
//  TRANSP_COLOR 16'h0000     colour value flagged as transparent
// PORTS
//  clk            in   1   single clock, all state on posedge
//  reset          in   1   asynchronous, active-high reset
//  in_valid       in   1   request present on tile_number/offset_x/offset_y
//  in_ready       out  1   block can accept a request this cycle
//  tile_number    in   16  tile index
//  offset_x       in   8   pixel column inside tile, legal 0..9
//  offset_y       in   8   pixel row inside tile, legal 0..9
//  cache_flush    in   1   one-cycle pulse; invalidates reuse buffer
//  mem_req        out  1   memory read request, held until mem_ack
//  address        out  30  word address of read, stable while mem_req=1
//  mem_ack        in   1   data valid on mem_data this cycle, completes request
//  mem_data       in   32  read word; bits[31:16]=even pixel, bits[15:0]=odd pixel
//  out_valid      out  1   pixel_color valid
//  out_ready      in   1   consumer accepts pixel this cycle
//  pixel_color    out  16  fetched colour, RGB565
//  transparent    out  1   pixel_color == TRANSP_COLOR, or offset illegal
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; mem_req=0; address=0; out_valid=0; pixel_color=0; transparent=0; buffer invalid.
//  Address arithmetic, done at accept, 30-bit unsigned, wraps mod 2^30:
//   p = offset_y*10 + offset_x (0..99). word = TILE_BASE + tile_number*50 + p>>1. half = p[0].
//  FSM IDLE/REQ/OUT:
//   IDLE: in_ready=1. On in_valid, latch the inputs and compute word/half. Next state:
//     offset_x>9 or offset_y>9 -> OUT with pixel_color=0, transparent=1, no memory access.
//     buffer valid, buf_addr==word and no cache_flush this cycle -> OUT (hit).
//     otherwise -> REQ (miss).
//   REQ: mem_req=1 and address=word, both registered. On mem_ack, write mem_data into the buffer,
//     set buf_addr=word and buffer valid, select the half, then -> OUT.
//   OUT: out_valid=1; pixel_color/transparent held stable. On out_ready -> IDLE (no same-cycle re-accept).
//  in_ready is 1 only in IDLE. Accept, ack and output handshakes complete when both signals are high at posedge.
//  Latency from accept edge: hit/illegal -> out_valid high next cycle.
//   Miss -> mem_req high next cycle; out_valid high the cycle after the mem_ack edge.
//  Half select: half=0 -> data[31:16]; half=1 -> data[15:0]. transparent = (color == TRANS_COLOR).
//  cache_flush: clears buffer valid in any state.
//   With accept in IDLE: flush wins and the request is a miss.
//   With mem_ack in REQ: the acked data is still output, but the buffer stays invalid.
//  mem_ack outside REQ is ignored.
//  Reset mid-operation (including REQ): abandon the request immediately. mem_req drops asynchronously
//   and a late mem_ack is ignored.
// TESTING
//  1 TILE_BASE=0x1000, tile=3, ox=5, oy=2, empty buffer -> p=25, mem_req with address=0x10A2 one cycle after accept;
//    ack data=0xAAAA_1234 -> pixel_color=0x1234 one cycle later.
//  2 Next request tile=3, ox=4, oy=2 -> hit on 0x10A2, no mem_req, out_valid 1 cycle after accept,
//    pixel_color=0xAAAA.
//  3 Request ox=10, oy=0 -> no mem_req; pixel_color=0, transparent=1.
//    Separately, an ack word whose selected half is 0x0000 -> transparent=1.
//  4 cache_flush pulse, then repeat scenario 2 -> mem_req with address=0x10A2 (miss).
//    Flush coincident with mem_ack -> output correct, the next same-word request misses.
//  5 Hold out_ready=0 for 3 cycles in OUT -> out_valid, pixel_color stable; in_ready=0; new in_valid not accepted.
//  6 Assert reset while mem_req=1 -> mem_req=0 immediately, state IDLE, buffer invalid; a mem_ack after reset has no effect.

Source files
------------

// File: rtl/tile_pixel_fetch.sv
// rtl/tile_pixel_fetch.sv - fetch one 16-bit tile pixel from tile-graphics memory
// with a one-word reuse buffer.
module tile_pixel_fetch #(
  parameter logic [29:0] TILE_BASE    = 30'h0001000,
  parameter logic [15:0] TRANSP_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] tile_number,
  input  logic [7:0]  offset_x,
  input  logic [7:0]  offset_y,
  input  logic        cache_flush,
  output logic        mem_req,
  output logic [29:0] address,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pixel_color,
  output logic        transparent
);

  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  state_t      state, state_nx;
  logic [29:0] pix_idx;
  logic [29:0] word;
  logic        half;
  logic        illegal;
  logic        hit;
  logic        accept;
  logic        ack;
  logic        req_half;
  logic        buf_valid;
  logic [29:0] buf_addr;
  logic [31:0] buf_data;
  logic [15:0] hit_color;
  logic [15:0] ack_color;

  assign pix_idx   = 30'(offset_y) * 30'd10 + 30'(offset_x);
  assign word      = TILE_BASE + 30'(tile_number) * 30'd50 + (pix_idx >> 1);
  assign half      = pix_idx[0];
  assign illegal   = (offset_x > 8'd9) || (offset_y > 8'd9);
  // A flush arriving with the request must force a miss.
  assign hit       = buf_valid && (buf_addr == word) && !cache_flush;
  assign accept    = (state == IDLE) && in_valid;
  assign ack       = (state == REQ) && mem_ack;
  assign hit_color = half ? buf_data[15:0] : buf_data[31:16];
  assign ack_color = req_half ? mem_data[15:0] : mem_data[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (illegal || hit) ? OUT : REQ;
      end
      REQ: if (mem_ack) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req     <= 1'b0;
      address     <= '0;
      pixel_color <= '0;
      transparent <= 1'b0;
      req_half    <= 1'b0;
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
    end else begin
      if (cache_flush) buf_valid <= 1'b0;
      if (accept) begin
        req_half <= half;
        if (illegal) begin
          pixel_color <= '0;
          transparent <= 1'b1;
        end else if (hit) begin
          pixel_color <= hit_color;
          transparent <= (hit_color == TRANSP_COLOR);
        end else begin
          mem_req <= 1'b1;
          address <= word;
        end
      end
      // Acked data is always delivered; only buffer validity honours a flush.
      if (ack) begin
        mem_req     <= 1'b0;
        buf_data    <= mem_data;
        buf_addr    <= address;
        if (!cache_flush) buf_valid <= 1'b1;
        pixel_color <= ack_color;
        transparent <= (ack_color == TRANSP_COLOR);
      end
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// tb/tb_tile_pixel_fetch.sv - self-checking bench for tile_pixel_fetch
// against a word-address / reuse-buffer reference model.
module tb_tile_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] tile_number;
  logic [7:0]  offset_x;
  logic [7:0]  offset_y;
  logic        cache_flush;
  logic        mem_req;
  logic [29:0] address;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pixel_color;
  logic        transparent;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit          m_valid = 0;
  logic [29:0] m_addr;
  logic [31:0] m_data;

  tile_pixel_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .tile_number(tile_number), .offset_x(offset_x), .offset_y(offset_y),
    .cache_flush(cache_flush), .mem_req(mem_req), .address(address),
    .mem_ack(mem_ack), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .pixel_color(pixel_color), .transparent(transparent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] exp_word(input int tile, input int ox, input int oy);
    longint w;
    w = 64'h1000 + longint'(tile) * 50 + (oy * 10 + ox) / 2;
    return 30'(w % (64'd1 << 30));
  endfunction

  function automatic logic [15:0] pick(input logic [31:0] d, input int p);
    if (p % 2 == 1) return d[15:0];
    return 16'(d >> 16);
  endfunction

  task automatic do_req(input int tile, input int ox, input int oy, input bit flush,
                        input logic [31:0] data, input bit ack_flush, input int hold,
                        input string tag);
    bit          legal, hit;
    logic [29:0] w;
    logic [15:0] ec;
    bit          et;
    legal = (ox <= 9) && (oy <= 9);
    w     = exp_word(tile, ox, oy);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    tile_number = 16'(tile);
    offset_x    = 8'(ox);
    offset_y    = 8'(oy);
    cache_flush = flush;
    if (flush) m_valid = 0;
    hit = legal && m_valid && (m_addr == w);
    @(negedge clk);
    in_valid    = 1'b0;
    cache_flush = 1'b0;
    check({tag, ".out_valid_early"}, 32'(out_valid), 32'(!legal || hit));
    check({tag, ".mem_req"}, 32'(mem_req), 32'(legal && !hit));
    if (!legal) ec = 16'h0000;
    else if (hit) ec = pick(m_data, oy * 10 + ox);
    else begin
      check({tag, ".address"}, 32'(address), 32'(w));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mem_ack     = 1'b1;
      mem_data    = data;
      cache_flush = ack_flush;
      @(negedge clk);
      mem_ack     = 1'b0;
      cache_flush = 1'b0;
      if (ack_flush) m_valid = 0;
      else begin
        m_valid = 1;
        m_addr  = w;
        m_data  = data;
      end
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".mem_req_drop"}, 32'(mem_req), 32'd0);
      ec = pick(data, oy * 10 + ox);
    end
    et = legal ? (ec == 16'h0000) : 1'b1;
    check({tag, ".color"}, 32'(pixel_color), 32'(ec));
    check({tag, ".transp"}, 32'(transparent), 32'(et));
    if (hold > 0) begin
      in_valid    = 1'b1;
      tile_number = 16'(tile + 1);
      offset_x    = 8'd0;
      offset_y    = 8'd0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".hold_color"}, 32'(pixel_color), 32'(ec));
        check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".done_rdy"}, 32'(in_ready), 32'd1);
    check({tag, ".done_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; tile_number = '0; offset_x = '0; offset_y = '0;
    cache_flush = 1'b0; mem_ack = 1'b0; mem_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.address", 32'(address), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.color", 32'(pixel_color), 32'd0);
    check("rst.transp", 32'(transparent), 32'd0);
    reset = 1'b0;

    do_req(3, 5, 2, 0, 32'hAAAA_1234, 0, 0, "t1_miss");
    check("t1.addr_const", 32'(address), 32'h10A2);
    do_req(3, 4, 2, 0, 32'h0, 0, 0, "t2_hit");
    do_req(3, 10, 0, 0, 32'h0, 0, 0, "t3_illegal_x");
    do_req(3, 0, 12, 0, 32'h0, 0, 0, "t3_illegal_y");
    do_req(7, 0, 0, 0, 32'h0000_5555, 0, 0, "t3_zero_half");
    do_req(7, 1, 0, 0, 32'h0, 0, 0, "t3_hit_odd");

    do_req(3, 5, 2, 0, 32'hAAAA_1234, 0, 0, "t4_load");
    @(negedge clk); cache_flush = 1'b1; m_valid = 0;
    @(negedge clk); cache_flush = 1'b0;
    do_req(3, 4, 2, 0, 32'hBBBB_CCCC, 0, 0, "t4_after_flush");
    do_req(5, 1, 1, 0, 32'h1357_2468, 1, 0, "t4_flush_at_ack");
    do_req(5, 0, 1, 0, 32'h1357_2468, 0, 0, "t4_miss_again");
    do_req(5, 0, 1, 0, 32'h0, 0, 0, "t4_hit_again");
    do_req(5, 1, 1, 1, 32'h9999_0000, 0, 0, "t4_flush_at_accept");

    do_req(6, 9, 9, 0, 32'hDEAD_BEEF, 0, 3, "t5_hold_miss");
    do_req(6, 8, 9, 0, 32'h0, 0, 3, "t5_hold_hit");

    @(negedge clk);
    in_valid = 1'b1; tile_number = 16'd9; offset_x = 8'd2; offset_y = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("t6.mem_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6.mem_req_async", 32'(mem_req), 32'd0);
    check("t6.in_ready", 32'(in_ready), 32'd1);
    m_valid = 0;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_data = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t6.late_ack_valid", 32'(out_valid), 32'd0);
    check("t6.late_ack_req", 32'(mem_req), 32'd0);
    check("t6.late_ack_rdy", 32'(in_ready), 32'd1);
    do_req(9, 2, 3, 0, 32'h0F0F_F0F0, 0, 0, "t6_after_reset");

    for (int i = 0; i < 30; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 4) == 0) d[15:0] = 16'h0;
      if ($urandom_range(0, 4) == 0) d[31:16] = 16'h0;
      do_req($urandom_range(0, 2), $urandom_range(0, 10), $urandom_range(0, 10),
             $urandom_range(0, 7) == 0, d, $urandom_range(0, 7) == 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
